// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - entry/exit barrier front-end (optional event counters: GATE_EVENT_COUNT_EN)
module parking_gate_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CARD_TIMEOUT    = 1000,
  parameter int PASS_TIMEOUT    = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic entry_loop,
  input  logic entry_beam,
  input  logic exit_loop,
  input  logic exit_beam,
  input  logic entry_card_valid,
  input  logic entry_card_is_uni,
  input  logic exit_card_valid,
  input  logic exit_card_is_uni,
  input  logic uni_is_vacated_space,
  input  logic is_vacated_space,
  output logic entry_barrier_open,
  output logic exit_barrier_open,
  output logic entry_reject,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited
`ifdef GATE_EVENT_COUNT_EN
  ,
  output logic [15:0] entries_total,
  output logic [15:0] exits_total,
  output logic [15:0] rejects_total
`endif
);

  localparam int TMAX = (CARD_TIMEOUT > PASS_TIMEOUT) ? CARD_TIMEOUT : PASS_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CARD, S_HOLD, S_OPEN, S_CLOSE} gate_state_t;

  // Sensor bit order: 0 entry_loop, 1 entry_beam, 2 exit_loop, 3 exit_beam
  logic [3:0]    w_raw;
  logic [3:0]    r_sync1, r_sync2, r_deb, r_deb_d;
  logic [DW-1:0] r_cnt [4];
  logic [3:0]    w_rise;

  assign w_raw  = {exit_beam, exit_loop, entry_beam, entry_loop};
  assign w_rise = r_deb & ~r_deb_d;

  // Two-flop synchronizers for the asynchronous sensor inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncers: level flips after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_deb_d <= r_deb;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + DW'(1);
        end
      end
    end
  end

  gate_state_t   r_en_state, w_en_next, r_ex_state, w_ex_next;
  logic [TW-1:0] r_en_timer, r_ex_timer;
  logic          r_en_cls, r_ex_cls;
  logic          w_en_open, w_en_reject, w_en_event, w_en_latch;
  logic          w_ex_open, w_ex_event, w_ex_latch, w_ex_cls_d;

  // Entry FSM next-state and outputs; space is checked against the card class in the strobe cycle
  always_comb begin
    w_en_next   = r_en_state;
    w_en_open   = 1'b0;
    w_en_reject = 1'b0;
    w_en_event  = 1'b0;
    w_en_latch  = 1'b0;
    case (r_en_state)
      S_IDLE:  if (w_rise[0]) w_en_next = S_CARD;
      S_CARD: begin
        if (entry_card_valid) begin
          w_en_latch = 1'b1;
          if (entry_card_is_uni ? uni_is_vacated_space : is_vacated_space) begin
            w_en_next = S_OPEN;
          end else begin
            w_en_reject = 1'b1;
            w_en_next   = S_HOLD;
          end
        end else if (r_en_timer >= TW'(CARD_TIMEOUT)) begin
          w_en_reject = 1'b1;
          w_en_next   = S_HOLD;
        end
      end
      S_HOLD:  if (!r_deb[0]) w_en_next = S_IDLE;
      S_OPEN: begin
        w_en_open = 1'b1;
        if (w_rise[1]) begin
          w_en_event = 1'b1;
          w_en_next  = S_CLOSE;
        end else if (r_en_timer >= TW'(PASS_TIMEOUT)) begin
          w_en_next = S_CLOSE;
        end
      end
      S_CLOSE: if (!r_deb[0] && !r_deb[1]) w_en_next = S_IDLE;
      default: w_en_next = S_IDLE;
    endcase
  end

  // Exit FSM next-state and outputs; a card timeout still opens, as class "other"
  always_comb begin
    w_ex_next  = r_ex_state;
    w_ex_open  = 1'b0;
    w_ex_event = 1'b0;
    w_ex_latch = 1'b0;
    w_ex_cls_d = 1'b0;
    case (r_ex_state)
      S_IDLE:  if (w_rise[2]) w_ex_next = S_CARD;
      S_CARD: begin
        if (exit_card_valid) begin
          w_ex_latch = 1'b1;
          w_ex_cls_d = exit_card_is_uni;
          w_ex_next  = S_OPEN;
        end else if (r_ex_timer >= TW'(CARD_TIMEOUT)) begin
          w_ex_latch = 1'b1;
          w_ex_next  = S_OPEN;
        end
      end
      S_OPEN: begin
        w_ex_open = 1'b1;
        if (w_rise[3]) begin
          w_ex_event = 1'b1;
          w_ex_next  = S_CLOSE;
        end else if (r_ex_timer >= TW'(PASS_TIMEOUT)) begin
          w_ex_next = S_CLOSE;
        end
      end
      S_CLOSE: if (!r_deb[2] && !r_deb[3]) w_ex_next = S_IDLE;
      default: w_ex_next = S_IDLE;
    endcase
  end

  // State registers, per-state saturating timers (cleared on every transition) and latched card class
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_state <= S_IDLE;
      r_ex_state <= S_IDLE;
      r_en_timer <= '0;
      r_ex_timer <= '0;
      r_en_cls   <= 1'b0;
      r_ex_cls   <= 1'b0;
    end else begin
      r_en_state <= w_en_next;
      r_ex_state <= w_ex_next;
      if (w_en_next != r_en_state) r_en_timer <= '0;
      else if (r_en_timer != '1)   r_en_timer <= r_en_timer + TW'(1);
      if (w_ex_next != r_ex_state) r_ex_timer <= '0;
      else if (r_ex_timer != '1)   r_ex_timer <= r_ex_timer + TW'(1);
      if (w_en_latch) r_en_cls <= entry_card_is_uni;
      if (w_ex_latch) r_ex_cls <= w_ex_cls_d;
    end
  end

  assign entry_barrier_open = w_en_open;
  assign exit_barrier_open  = w_ex_open;
  assign entry_reject       = w_en_reject;
  assign car_entered        = w_en_event;
  assign is_uni_car_entered = w_en_event & r_en_cls;
  assign car_exited         = w_ex_event;
  assign is_uni_car_exited  = w_ex_event & r_ex_cls;

`ifdef GATE_EVENT_COUNT_EN
  logic [15:0] r_entries_total, r_exits_total, r_rejects_total;

  // Wrapping event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entries_total <= '0;
      r_exits_total   <= '0;
      r_rejects_total <= '0;
    end else begin
      if (w_en_event)  r_entries_total <= r_entries_total + 16'd1;
      if (w_ex_event)  r_exits_total   <= r_exits_total + 16'd1;
      if (w_en_reject) r_rejects_total <= r_rejects_total + 16'd1;
    end
  end

  assign entries_total = r_entries_total;
  assign exits_total   = r_exits_total;
  assign rejects_total = r_rejects_total;
`endif

endmodule

// File: tb/tb_parking_gate_controller.sv
// tb/tb_parking_gate_controller.sv - directed self-checking bench for parking_gate_controller
module tb_parking_gate_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic entry_loop = 0, entry_beam = 0, exit_loop = 0, exit_beam = 0;
  logic entry_card_valid = 0, entry_card_is_uni = 0, exit_card_valid = 0, exit_card_is_uni = 0;
  logic uni_is_vacated_space = 0, is_vacated_space = 0;
  logic entry_barrier_open, exit_barrier_open, entry_reject;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic [6:0] obs;
  int n_cmp = 0;
  int n_err = 0;

  parking_gate_controller #(
    .DEBOUNCE_CYCLES(4),
    .CARD_TIMEOUT(10),
    .PASS_TIMEOUT(20)
  ) dut (
    .clk(clk), .rst(rst),
    .entry_loop(entry_loop), .entry_beam(entry_beam),
    .exit_loop(exit_loop), .exit_beam(exit_beam),
    .entry_card_valid(entry_card_valid), .entry_card_is_uni(entry_card_is_uni),
    .exit_card_valid(exit_card_valid), .exit_card_is_uni(exit_card_is_uni),
    .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
    .entry_barrier_open(entry_barrier_open), .exit_barrier_open(exit_barrier_open),
    .entry_reject(entry_reject), .car_entered(car_entered),
    .is_uni_car_entered(is_uni_car_entered), .car_exited(car_exited),
    .is_uni_car_exited(is_uni_car_exited)
  );

  always #5 clk = ~clk;

  // {entry_open, reject, car_entered, uni_entered, exit_open, car_exited, uni_exited}
  assign obs = {entry_barrier_open, entry_reject, car_entered, is_uni_car_entered,
                exit_barrier_open, car_exited, is_uni_car_exited};

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    cyc(3);
    n_cmp++;
    if (obs !== 7'b0) begin n_err++; $display("FAIL reset_outputs obs=%b exp=%b", obs, 7'b0); end
    rst = 1'b0;
    cyc(2);
    n_cmp++;
    if (obs !== 7'b0) begin n_err++; $display("FAIL after_reset obs=%b exp=%b", obs, 7'b0); end
  endtask

  task automatic test_entry_uni;
    logic [6:0] exp;
    entry_loop = 1'b1;
    cyc(7);
    n_cmp++;
    if (obs !== 7'b0) begin n_err++; $display("FAIL entry_card_wait obs=%b exp=%b", obs, 7'b0); end
    uni_is_vacated_space = 1'b1; entry_card_is_uni = 1'b1; entry_card_valid = 1'b1;
    cyc(1);
    entry_card_valid = 1'b0; entry_card_is_uni = 1'b0;
    n_cmp++;
    if (obs !== 7'b1000000) begin n_err++; $display("FAIL open_after_strobe obs=%b exp=%b", obs, 7'b1000000); end
    entry_beam = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      exp = {k < 7, 1'b0, k == 6, k == 6, 3'b000};
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL entry_uni_k%0d obs=%b exp=%b", k, obs, exp); end
    end
    entry_loop = 1'b0; entry_beam = 1'b0; uni_is_vacated_space = 1'b0;
    cyc(10);
    n_cmp++;
    if (obs !== 7'b0) begin n_err++; $display("FAIL entry_idle obs=%b exp=%b", obs, 7'b0); end
  endtask

  task automatic test_reject;
    int opened, rejects;
    entry_loop = 1'b1;
    cyc(7);
    is_vacated_space = 1'b0; entry_card_is_uni = 1'b0; entry_card_valid = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 7'b0100000) begin n_err++; $display("FAIL reject_pulse obs=%b exp=%b", obs, 7'b0100000); end
    cyc(1);
    entry_card_valid = 1'b0;
    opened = 0; rejects = 0;
    for (int i = 0; i < 12; i++) begin
      entry_card_valid = (i == 3);
      is_vacated_space = (i == 3);
      #1;
      if (entry_barrier_open) opened++;
      if (entry_reject) rejects++;
      cyc(1);
    end
    entry_card_valid = 1'b0; is_vacated_space = 1'b0;
    n_cmp++;
    if (opened != 0 || rejects != 0) begin
      n_err++; $display("FAIL hold_quiet opened=%0d rejects=%0d exp=0/0", opened, rejects);
    end
    entry_loop = 1'b0;
    cyc(10);
    entry_loop = 1'b1;
    cyc(7);
    is_vacated_space = 1'b1; entry_card_valid = 1'b1;
    cyc(1);
    entry_card_valid = 1'b0; is_vacated_space = 1'b0;
    n_cmp++;
    if (obs !== 7'b1000000) begin n_err++; $display("FAIL reopen_after_hold obs=%b exp=%b", obs, 7'b1000000); end
  endtask

  task automatic test_pass_timeout;
    logic [6:0] exp;
    for (int m = 1; m <= 21; m++) begin
      cyc(1);
      exp = {m <= 20, 6'b0};
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL pass_tmo_m%0d obs=%b exp=%b", m, obs, exp); end
    end
    entry_loop = 1'b0;
    cyc(10);
  endtask

  task automatic test_card_timeout;
    logic [6:0] exp;
    entry_loop = 1'b1;
    cyc(7);
    for (int m = 1; m <= 11; m++) begin
      cyc(1);
      exp = {1'b0, m == 10, 5'b0};
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL entry_card_tmo_m%0d obs=%b exp=%b", m, obs, exp); end
    end
    entry_loop = 1'b0;
    cyc(10);
    exit_loop = 1'b1;
    cyc(7);
    for (int m = 1; m <= 11; m++) begin
      cyc(1);
      exp = {4'b0, m == 11, 2'b00};
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL exit_card_tmo_m%0d obs=%b exp=%b", m, obs, exp); end
    end
    exit_beam = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      exp = {4'b0, 1'b1, k == 6, 1'b0};
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL exit_tmo_pass_k%0d obs=%b exp=%b", k, obs, exp); end
    end
    exit_loop = 1'b0; exit_beam = 1'b0;
    cyc(10);
    n_cmp++;
    if (obs !== 7'b0) begin n_err++; $display("FAIL exit_idle obs=%b exp=%b", obs, 7'b0); end
  endtask

  task automatic test_simultaneous;
    entry_loop = 1'b1; exit_loop = 1'b1;
    cyc(7);
    is_vacated_space = 1'b1; entry_card_is_uni = 1'b0; entry_card_valid = 1'b1;
    exit_card_is_uni = 1'b1; exit_card_valid = 1'b1;
    cyc(1);
    entry_card_valid = 1'b0; exit_card_valid = 1'b0; exit_card_is_uni = 1'b0; is_vacated_space = 1'b0;
    n_cmp++;
    if (obs !== 7'b1000100) begin n_err++; $display("FAIL both_open obs=%b exp=%b", obs, 7'b1000100); end
    entry_beam = 1'b1; exit_beam = 1'b1;
    cyc(5);
    n_cmp++;
    if (obs !== 7'b1000100) begin n_err++; $display("FAIL both_pre_event obs=%b exp=%b", obs, 7'b1000100); end
    cyc(1);
    n_cmp++;
    if (obs !== 7'b1010111) begin n_err++; $display("FAIL both_events obs=%b exp=%b", obs, 7'b1010111); end
    cyc(1);
    n_cmp++;
    if (obs !== 7'b0) begin n_err++; $display("FAIL both_closed obs=%b exp=%b", obs, 7'b0); end
    entry_loop = 1'b0; exit_loop = 1'b0; entry_beam = 1'b0; exit_beam = 1'b0;
    cyc(10);
  endtask

  task automatic test_glitch_and_reset;
    int events, closed;
    entry_loop = 1'b1;
    cyc(7);
    uni_is_vacated_space = 1'b1; entry_card_is_uni = 1'b1; entry_card_valid = 1'b1;
    cyc(1);
    entry_card_valid = 1'b0; entry_card_is_uni = 1'b0; uni_is_vacated_space = 1'b0;
    events = 0; closed = 0;
    for (int i = 0; i < 16; i++) begin
      entry_beam = ((i % 4) < 2);
      cyc(1);
      if (car_entered) events++;
      if (!entry_barrier_open) closed++;
    end
    entry_beam = 1'b0;
    n_cmp++;
    if (events != 0 || closed != 0) begin
      n_err++; $display("FAIL glitch_beam events=%0d closed=%0d exp=0/0", events, closed);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 7'b0) begin n_err++; $display("FAIL rst_mid_open obs=%b exp=%b", obs, 7'b0); end
    cyc(2);
    rst = 1'b0;
    uni_is_vacated_space = 1'b1; entry_card_is_uni = 1'b1; entry_card_valid = 1'b1;
    cyc(1);
    entry_card_valid = 1'b0; entry_card_is_uni = 1'b0; uni_is_vacated_space = 1'b0;
    n_cmp++;
    if (obs !== 7'b0) begin n_err++; $display("FAIL idle_after_rst obs=%b exp=%b", obs, 7'b0); end
    entry_loop = 1'b0;
    cyc(30);
  endtask

  initial begin
    test_reset();
    test_entry_uni();
    test_reject();
    test_pass_timeout();
    test_card_timeout();
    test_simultaneous();
    test_glitch_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
